// File: rtl/keypad_scan_fsm.sv
// keypad_scan_fsm: scans a 4x4 active-low keypad matrix, debounces one key at a time,
// and presents it as a hex code with a level new_hex flag held for the whole press.
// Ports:
//   clk     - system clock, rising edge
//   reset   - asynchronous active-low reset
//   rows    - keypad rows, active-low, asynchronous to clk
//   cols    - column drive, active-low, exactly one bit low
//   new_hex - high while a debounced key is held (including release debounce)
//   hex_out - code of the most recently accepted key
module keypad_scan_fsm #(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic       new_hex,
    output logic [3:0] hex_out
);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int BW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] DB_LAST  = BW'(DEBOUNCE_CYCLES - 1);
    // Nibble {row,col} holds the key code; row 0 top, col 0 left.
    localparam logic [63:0] KEYMAP = 64'hDF0E_C987_B654_A321;

    typedef enum logic [1:0] {SCAN, PRESS_DB, HELD, REL_DB} state_t;

    state_t        state, state_n;
    logic [3:0]    rows_m, rows_s;
    logic [1:0]    col, col_n;
    logic [1:0]    key_row, key_row_n;
    logic [1:0]    key_col, key_col_n;
    logic [1:0]    low_row;
    logic [DW-1:0] div_cnt, div_cnt_n;
    logic [BW-1:0] db_cnt, db_cnt_n;
    logic [3:0]    hex_n;
    logic          key_low;

    assign cols    = ~(4'b0001 << col);
    assign low_row = !rows_s[0] ? 2'd0 : !rows_s[1] ? 2'd1 : !rows_s[2] ? 2'd2 : 2'd3;
    assign key_low = !rows_s[key_row];

    always_comb begin
        state_n   = state;
        col_n     = col;
        key_row_n = key_row;
        key_col_n = key_col;
        div_cnt_n = div_cnt;
        db_cnt_n  = db_cnt;
        hex_n     = hex_out;
        case (state)
            SCAN: begin
                if (div_cnt != DIV_LAST) begin
                    div_cnt_n = div_cnt + 1'b1;
                end else if (rows_s != 4'hF) begin
                    state_n   = PRESS_DB;
                    key_row_n = low_row;
                    key_col_n = col;
                    db_cnt_n  = '0;
                end else begin
                    col_n     = col + 2'd1;
                    div_cnt_n = '0;
                end
            end
            PRESS_DB: begin
                if (!key_low) begin
                    state_n   = SCAN;
                    col_n     = col + 2'd1;
                    div_cnt_n = '0;
                end else if (db_cnt == DB_LAST) begin
                    state_n = HELD;
                    hex_n   = KEYMAP[{key_row, key_col, 2'b00} +: 4];
                end else begin
                    db_cnt_n = db_cnt + 1'b1;
                end
            end
            HELD: begin
                if (!key_low) begin
                    state_n  = REL_DB;
                    db_cnt_n = '0;
                end
            end
            REL_DB: begin
                if (key_low) begin
                    state_n  = HELD;
                    db_cnt_n = '0;
                end else if (db_cnt == DB_LAST) begin
                    state_n   = SCAN;
                    col_n     = key_col + 2'd1;
                    div_cnt_n = '0;
                end else begin
                    db_cnt_n = db_cnt + 1'b1;
                end
            end
            default: state_n = SCAN;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rows_m  <= 4'hF;
            rows_s  <= 4'hF;
            state   <= SCAN;
            col     <= 2'd0;
            key_row <= 2'd0;
            key_col <= 2'd0;
            div_cnt <= '0;
            db_cnt  <= '0;
            hex_out <= 4'h0;
            new_hex <= 1'b0;
        end else begin
            rows_m  <= rows;
            rows_s  <= rows_m;
            state   <= state_n;
            col     <= col_n;
            key_row <= key_row_n;
            key_col <= key_col_n;
            div_cnt <= div_cnt_n;
            db_cnt  <= db_cnt_n;
            hex_out <= hex_n;
            // Registered alongside state so it is high exactly in HELD and REL_DB.
            new_hex <= (state_n == HELD) || (state_n == REL_DB);
        end
    end
endmodule

// File: tb/tb_keypad_scan_fsm.sv
// tb_keypad_scan_fsm: drives a modelled 4x4 keypad into keypad_scan_fsm and checks
// cols/new_hex/hex_out every cycle against a behavioural keypad-scanner model.
module tb_keypad_scan_fsm;
    localparam int SD = 4;
    localparam int DB = 8;

    logic        clk;
    logic        reset;
    logic [3:0]  rows;
    logic [3:0]  cols;
    logic        new_hex;
    logic [3:0]  hex_out;
    logic [15:0] pressed;

    int checks = 0;
    int errors = 0;
    int rises  = 0;
    logic nh_prev = 1'b0;

    keypad_scan_fsm #(.SCAN_DIV(SD), .DEBOUNCE_CYCLES(DB)) dut (
        .clk(clk), .reset(reset), .rows(rows), .cols(cols),
        .new_hex(new_hex), .hex_out(hex_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Key index is row*4+col; a pressed key pulls its row low when its column is driven.
    function automatic logic [3:0] rows_of(input logic [15:0] p, input logic [3:0] cv);
        logic [3:0] r;
        r = 4'hF;
        for (int i = 0; i < 16; i++)
            if (p[i] && !cv[i % 4]) r[i / 4] = 1'b0;
        return r;
    endfunction

    assign rows = rows_of(pressed, cols);

    // Model: scan position as one counter over 4*SD cycles, key = -1 while scanning,
    // press accepted on the DB-th consecutive low sample, release on the (DB+1)-th high.
    logic [3:0] km [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                            4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};
    int m_scan, m_key, m_run;
    bit m_held;
    logic [3:0] m_h0, m_h1, m_hex;

    function automatic int m_col();
        return m_key >= 0 ? m_key % 4 : m_scan / SD;
    endfunction

    function automatic logic [3:0] m_cols();
        return 4'hF ^ (4'b0001 << m_col());
    endfunction

    task automatic model_reset();
        m_scan = 0; m_key = -1; m_run = 0; m_held = 0;
        m_h0 = 4'hF; m_h1 = 4'hF; m_hex = 4'h0;
    endtask

    task automatic model_step();
        logic [3:0] raw, rs;
        int r;
        raw = rows_of(pressed, m_cols());
        rs  = m_h1;
        if (m_key < 0) begin
            if (m_scan % SD == SD - 1 && rs != 4'hF) begin
                r = 0;
                while (rs[r]) r++;
                m_key = r * 4 + m_scan / SD; m_run = 0; m_held = 0;
            end else m_scan = (m_scan + 1) % (4 * SD);
        end else if (!m_held) begin
            if (!rs[m_key / 4]) begin
                m_run++;
                if (m_run == DB) begin m_held = 1; m_run = 0; m_hex = km[m_key]; end
            end else begin
                m_scan = ((m_key % 4 + 1) % 4) * SD; m_key = -1;
            end
        end else if (!rs[m_key / 4]) begin
            m_run = 0;
        end else begin
            m_run++;
            if (m_run == DB + 1) begin m_scan = ((m_key % 4 + 1) % 4) * SD; m_key = -1; end
        end
        m_h1 = m_h0;
        m_h0 = raw;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) model_reset();
            else model_step();
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        chk("model_cols", 32'(cols), 32'(m_cols()));
        chk("model_new_hex", 32'(new_hex), 32'(m_key >= 0 && m_held));
        chk("model_hex_out", 32'(hex_out), 32'(m_hex));
        if (new_hex && !nh_prev) rises++;
        nh_prev = new_hex;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_nh(input logic v, input int budget, output int n);
        n = 0;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (new_hex === v) begin n = i; break; end
        end
        if (n == 0) begin
            checks++; errors++;
            $display("FAIL wait_new_hex timeout waiting for %0b after %0d cycles", v, budget);
        end
    endtask

    initial begin
        int n, r0;
        bit ok;
        reset   = 1'b0;
        pressed = 16'h0;
        ticks(3);
        chk("reset_cols", 32'(cols), 32'h0000_000E);
        chk("reset_new_hex", 32'(new_hex), 32'h0);
        chk("reset_hex_out", 32'(hex_out), 32'h0);
        @(posedge clk); #2 reset = 1'b1;
        for (int k = 0; k <= 16; k++) begin
            tick();
            if (k == 0 || k == 3) chk("idle_col0", 32'(cols), 32'hE);
            if (k == 4)  chk("idle_col1", 32'(cols), 32'hD);
            if (k == 8)  chk("idle_col2", 32'(cols), 32'hB);
            if (k == 12) chk("idle_col3", 32'(cols), 32'h7);
            if (k == 16) chk("idle_wrap", 32'(cols), 32'hE);
        end

        // clean press of "6" at (1,2)
        pressed = 16'h0; pressed[6] = 1'b1;
        wait_nh(1'b1, 100, n);
        chk("press6_hex", 32'(hex_out), 32'h6);
        ok = 1;
        for (int i = 0; i < 40; i++) begin tick(); ok &= (cols === 4'hB) && new_hex; end
        chk("press6_hold_cols", 32'(ok), 32'h1);
        pressed = 16'h0;
        wait_nh(1'b0, 50, n);
        chk("press6_release_latency", 32'(n), 32'd11);
        chk("press6_next_col", 32'(cols), 32'h7);

        // press bounce on "0" at (3,1)
        r0 = rises; ok = 1;
        pressed[13] = 1'b1;
        for (int i = 0; i < 5; i++) begin tick(); ok &= !new_hex; end
        pressed = 16'h0;
        for (int i = 0; i < 2; i++) begin tick(); ok &= !new_hex; end
        chk("bounce_no_accept", 32'(ok), 32'h1);
        pressed[13] = 1'b1;
        wait_nh(1'b1, 100, n);
        chk("bounce_hex", 32'(hex_out), 32'h0);
        ticks(20);
        pressed = 16'h0;
        wait_nh(1'b0, 50, n);
        chk("bounce_single_pulse", 32'(rises - r0), 32'd1);

        // release bounce on "A" at (0,3)
        pressed[3] = 1'b1;
        wait_nh(1'b1, 100, n);
        ok = 1;
        ticks(3);
        pressed = 16'h0;
        for (int i = 0; i < 3; i++) begin tick(); ok &= new_hex; end
        pressed[3] = 1'b1;
        for (int i = 0; i < 20; i++) begin tick(); ok &= new_hex; end
        chk("relbounce_continuous", 32'(ok), 32'h1);
        chk("relbounce_hex", 32'(hex_out), 32'hA);
        pressed = 16'h0;
        wait_nh(1'b0, 50, n);

        // simultaneous (1,0)+(2,0), then "2" during hold
        pressed[4] = 1'b1; pressed[8] = 1'b1;
        wait_nh(1'b1, 100, n);
        chk("simul_hex", 32'(hex_out), 32'h4);
        pressed[1] = 1'b1;
        ok = 1;
        for (int i = 0; i < 30; i++) begin tick(); ok &= new_hex && hex_out === 4'h4; end
        chk("second_key_ignored", 32'(ok), 32'h1);
        pressed[4] = 1'b0; pressed[8] = 1'b0;
        wait_nh(1'b0, 50, n);
        chk("simul_release_latency", 32'(n), 32'd11);
        wait_nh(1'b1, 100, n);
        chk("second_key_after", 32'(hex_out), 32'h2);
        pressed = 16'h0;
        wait_nh(1'b0, 50, n);

        // mid-hold asynchronous reset with "F" at (3,2)
        pressed[14] = 1'b1;
        wait_nh(1'b1, 100, n);
        chk("f_hex", 32'(hex_out), 32'hF);
        @(posedge clk); #2 reset = 1'b0;
        #1;
        chk("async_new_hex", 32'(new_hex), 32'h0);
        chk("async_hex_out", 32'(hex_out), 32'h0);
        chk("async_cols", 32'(cols), 32'hE);
        ticks(2);
        @(posedge clk); #2 reset = 1'b1;
        wait_nh(1'b1, 100, n);
        chk("f_reaccept", 32'(hex_out), 32'hF);
        pressed = 16'h0;
        wait_nh(1'b0, 50, n);

        // random presses, bounces and multi-key patterns checked by the model
        for (int it = 0; it < 150; it++) begin
            pressed = 16'h0;
            case ($urandom_range(0, 3))
                0: ;
                3: begin
                    pressed[$urandom_range(0, 15)] = 1'b1;
                    pressed[$urandom_range(0, 15)] = 1'b1;
                end
                default: pressed[$urandom_range(0, 15)] = 1'b1;
            endcase
            ticks(int'($urandom_range(1, 40)));
        end
        pressed = 16'h0;
        ticks(60);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
